// File: rtl/cht_pkg.sv
// Shared types and helpers for the cht shift-chain receiver.
//   state_t   : receiver FSM state (IDLE, SHIFT)
//   DEF_WIDTH : default frame/word width
//   cnt_width : bit counter width able to hold 0..w
package cht_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cht_out_reg.sv
// One-entry valid/ready holding register with sticky overrun detect.
//   clk, rst  : clock, synchronous active-high clear
//   load      : a completed word is offered this cycle
//   data_in   : the completed word
//   par_data  : held word, stable while par_valid & ~par_ready
//   par_valid : word available
//   par_ready : downstream accepts when par_valid & par_ready
//   overrun   : sticky, a word was offered while the entry was full
module cht_out_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_data  <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      if (!par_valid || par_ready) begin
        par_data  <= data_in;
        par_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (par_valid && par_ready) begin
      par_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cht_shift_rx.sv
// Serial-in/parallel-out receiver: collects a framed, strobed bitstream
// MSB-first into a WIDTH-bit word and hands it to a valid/ready register.
//   clk, rst, clr : clock, synchronous resets (rst and clr act identically)
//   ser_en        : bit strobe
//   ser_in        : serial data bit
//   sof           : start of frame, marks the strobed bit as bit WIDTH-1
//   par_data      : assembled word
//   par_valid     : word available
//   par_ready     : downstream handshake
//   overrun       : sticky, completed word dropped
//   frame_err     : one-cycle pulse, sof arrived mid-frame
module cht_shift_rx
  import cht_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter bit          CONT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             sof,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx, sh_shift, sh_start;
  logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
  logic             armed, armed_nx;
  logic             fe_nx;
  logic             load;
  logic             kill;

  assign kill     = rst | clr;
  assign sh_shift = {sh[WIDTH-2:0], ser_in};
  assign sh_start = {{(WIDTH-1){1'b0}}, ser_in};
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (kill) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      sh        <= sh_nx;
      cnt       <= cnt_nx;
      armed     <= armed_nx;
      frame_err <= fe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
    armed_nx = armed;
    fe_nx    = 1'b0;
    load     = 1'b0;
    if (ser_en) begin
      case (state)
        IDLE: begin
          // In continuous mode a completed frame arms implicit framing.
          if (sof || (CONT && armed)) begin
            sh_nx    = sh_start;
            cnt_nx   = CW'(1);
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          // sof wins over completion: a restart never yields a word.
          if (sof) begin
            sh_nx  = sh_start;
            cnt_nx = CW'(1);
            fe_nx  = 1'b1;
          end else if (cnt_inc == CW'(WIDTH)) begin
            sh_nx    = sh_shift;
            cnt_nx   = '0;
            armed_nx = 1'b1;
            load     = 1'b1;
            state_nx = IDLE;
          end else begin
            sh_nx  = sh_shift;
            cnt_nx = cnt_inc;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  cht_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk      (clk),
    .rst      (kill),
    .load     (load),
    .data_in  (sh_shift),
    .par_data (par_data),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_cht_shift_rx.sv
// Self-checking bench: two receivers (CONT=0 and CONT=1, WIDTH=16) share the
// same stimulus and are compared every cycle against a frame-level model.
module tb_cht_shift_rx;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, clr, ser_en, ser_in, sof, par_ready;
  logic [W-1:0] d0, d1;
  logic v0, v1, ov0, ov1, fe0, fe1;

  int checks = 0;
  int errors = 0;
  int vcnt0, vcnt1, fecnt0;

  // model state, index = CONT value
  bit         m_active [2];
  logic [W-1:0] m_acc  [2];
  int         m_n      [2];
  bit         m_armed  [2];
  bit         m_v      [2];
  logic [W-1:0] m_d    [2];
  bit         m_ov     [2];
  bit         m_fe     [2];

  always #5 clk = ~clk;

  cht_shift_rx #(.WIDTH(W), .CONT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .ser_en(ser_en), .ser_in(ser_in),
    .sof(sof), .par_data(d0), .par_valid(v0), .par_ready(par_ready),
    .overrun(ov0), .frame_err(fe0)
  );

  cht_shift_rx #(.WIDTH(W), .CONT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .ser_en(ser_en), .ser_in(ser_in),
    .sof(sof), .par_data(d1), .par_valid(v1), .par_ready(par_ready),
    .overrun(ov1), .frame_err(fe1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: a frame is WIDTH strobed bits starting at a sof
  // (or, in continuous mode, at any strobe after the first frame).
  task automatic model_cycle(input int c);
    bit done;
    logic [W-1:0] word;
    done = 0;
    word = '0;
    if (rst || clr) begin
      m_active[c] = 0; m_acc[c] = '0; m_n[c] = 0; m_armed[c] = 0;
      m_v[c] = 0; m_d[c] = '0; m_ov[c] = 0; m_fe[c] = 0;
      return;
    end
    m_fe[c] = 0;
    if (ser_en) begin
      if (!m_active[c]) begin
        if (sof || (c == 1 && m_armed[c])) begin
          m_active[c] = 1; m_acc[c] = W'(ser_in); m_n[c] = 1;
        end
      end else if (sof) begin
        m_acc[c] = W'(ser_in); m_n[c] = 1; m_fe[c] = 1;
      end else begin
        m_acc[c] = W'(m_acc[c] * 2 + ser_in);
        m_n[c]++;
        if (m_n[c] == W) begin
          done = 1; word = m_acc[c];
          m_active[c] = 0; m_n[c] = 0; m_armed[c] = 1;
        end
      end
    end
    if (done) begin
      if (!m_v[c] || par_ready) begin m_d[c] = word; m_v[c] = 1; end
      else m_ov[c] = 1;
    end else if (m_v[c] && par_ready) begin
      m_v[c] = 0;
    end
  endtask

  task automatic step();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    check("valid0", v0, m_v[0]);   check("valid1", v1, m_v[1]);
    check("data0", d0, m_d[0]);    check("data1", d1, m_d[1]);
    check("ovr0", ov0, m_ov[0]);   check("ovr1", ov1, m_ov[1]);
    check("ferr0", fe0, m_fe[0]);  check("ferr1", fe1, m_fe[1]);
    if (v0) vcnt0++;
    if (v1) vcnt1++;
    if (fe0) fecnt0++;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nb,
                           input bit sf, input int gap);
    for (int k = 0; k < nb; k++) begin
      ser_en = 1'b1;
      ser_in = w[W-1-k];
      sof    = sf && (k == 0);
      step();
      ser_en = 1'b0;
      sof    = 1'b0;
      for (int g = 0; g < gap; g++) begin
        ser_in = 1'($urandom);
        step();
      end
    end
    ser_en = 1'b0;
    sof    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ser_en = 1'b0; ser_in = 1'b0; sof = 1'b0;
    par_ready = 1'b1;
    step();
    check("rst_data", d0, 0);
    check("rst_valid", v0, 0);
    rst = 1'b0;
    step();

    // back-to-back strobes, 1-cycle output latency
    send_bits(16'hA5C3, W, 1, 0);
    check("t1_data", d0, 16'hA5C3);
    check("t1_valid", v0, 1);
    step();
    check("t1_drop", v0, 0);

    // gapped strobes with noise between them
    send_bits(16'h0001, W, 1, 2);
    check("t2_data", d0, 16'h0001);

    // overrun
    par_ready = 1'b0;
    send_bits(16'h1234, W, 1, 0);
    send_bits(16'hFFFF, W, 1, 0);
    step();
    check("t3_data", d0, 16'h1234);
    check("t3_ovr", ov0, 1);
    par_ready = 1'b1;
    step();
    check("t3_valid", v0, 0);
    check("t3_ovr_hold", ov0, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t3_clr", ov0, 0);

    // mid-frame sof restarts the frame
    vcnt0 = 0; fecnt0 = 0;
    send_bits(16'h5555, 7, 1, 0);
    send_bits(16'hBEEF, W, 1, 0);
    step(); step();
    check("t4_ferr_cnt", fecnt0, 1);
    check("t4_words", vcnt0, 1);
    check("t4_data", d0, 16'hBEEF);

    // continuous framing vs sof-only framing
    rst = 1'b1; step(); rst = 1'b0;
    vcnt0 = 0; vcnt1 = 0;
    send_bits(16'h1111, W, 1, 0);
    send_bits(16'h2222, W, 0, 0);
    send_bits(16'h3333, W, 0, 0);
    step(); step();
    check("t5_words0", vcnt0, 1);
    check("t5_words1", vcnt1, 3);
    check("t5_data0", d0, 16'h1111);
    check("t5_data1", d1, 16'h3333);
    check("t5_ovr1", ov1, 0);

    // reset mid-frame leaves no residue
    send_bits(16'hFFFF, 9, 1, 0);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_data", d0, 0);
    send_bits(16'h8001, W, 1, 0);
    check("t6_data0", d0, 16'h8001);
    check("t6_data1", d1, 16'h8001);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ser_en    = ($urandom_range(0, 3) != 0);
      ser_in    = 1'($urandom);
      sof       = ($urandom_range(0, 19) == 0);
      par_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
